// File: rtl/mem_bridge_pkg.sv
// Shared widths and command/data types for the host-to-memory command bridge.
package mem_bridge_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef logic [DEF_DATA_W-1:0] mem_data_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        mem_data_t             wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; simultaneous push and pop is accepted when full.
module mem_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: non-blocking assignments on all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/mem_cmd_bridge.sv
// Queues host read/write commands, issues one registered memory strobe per cycle
// and returns read data through a credit-limited response FIFO.
module mem_cmd_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 2,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic              read_en,
    output logic [DATA_W-1:0] data_wr,
    input  logic [DATA_W-1:0] data_rd,
    output logic              busy
);

    localparam int CMD_W = $bits(mem_cmd_t);

    mem_cmd_t                     cmd_in;
    mem_cmd_t                     cmd_head;
    logic [CMD_W-1:0]             cmd_head_bits;
    logic                         cmd_full;
    logic                         cmd_empty;
    logic [$clog2(CMD_DEPTH):0]   cmd_count;
    logic                         cmd_push;
    logic                         issue;

    logic [DATA_W-1:0]            rsp_head;
    logic                         rsp_full;
    logic                         rsp_empty;
    logic [$clog2(RSP_DEPTH):0]   rsp_count;
    logic                         rsp_pop;

    logic [RD_LAT-1:0]            pend;
    logic [7:0]                   credit_use;
    logic                         credit_ok;

    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_head  = mem_cmd_t'(cmd_head_bits);
    assign cmd_ready = !rst && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;

    mem_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (issue),
        .rdata (cmd_head_bits),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // Credits cover the strobe on the bus, every read in the latency pipe and queued responses.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        credit_use = 8'(rsp_count);
        if (read_en) credit_use = credit_use + 8'd1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pend[i]) credit_use = credit_use + 8'd1;
        end
    end

    assign credit_ok = !rsp_full && (credit_use < 8'(RSP_DEPTH));
    assign issue     = !cmd_empty && (cmd_head.write || credit_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            address  <= '0;
            data_wr  <= '0;
            write_en <= 1'b0;
            read_en  <= 1'b0;
            pend     <= '0;
        end else begin
            write_en <= issue && cmd_head.write;
            read_en  <= issue && !cmd_head.write;
            if (issue)                  address <= cmd_head.addr;
            if (issue && cmd_head.write) data_wr <= cmd_head.wdata;
            pend[0] <= read_en;
            for (int i = 1; i < RD_LAT; i++) pend[i] <= pend[i-1];
        end
    end

    assign rsp_pop = rsp_valid && rsp_ready;

    mem_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend[RD_LAT-1]),
        .wdata (data_rd),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid = !rsp_empty;
    assign rsp_rdata = rsp_valid ? rsp_head : '0;
    assign busy      = (cmd_count != '0) || write_en || read_en || (|pend);

endmodule

// File: tb/tb_mem_cmd_bridge.sv
// Directed bench for mem_cmd_bridge with a 16x8 behavioural memory (RD_LAT=1) on the device side.
module tb_mem_cmd_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic [3:0] address;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_wr;
    logic [7:0] data_rd;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    mem_cmd_bridge #(.ADDR_W(4), .DATA_W(8), .CMD_DEPTH(4), .RSP_DEPTH(2), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .address   (address),
        .write_en  (write_en),
        .read_en   (read_en),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .busy      (busy)
    );

    // Device model: read_en sampled at an edge, data_rd valid one cycle later.
    logic [7:0] mem [16];
    logic [7:0] exp_mem [16];
    logic [7:0] rd_q = '0;
    always @(posedge clk) begin
        if (write_en) mem[address] <= data_wr;
        if (read_en)  rd_q <= mem[address];
    end
    assign data_rd = rd_q;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic w; logic [3:0] a; logic [7:0] d; } strobe_t;
    typedef struct { int cyc; logic [7:0] d; } rsp_t;
    strobe_t strobes[$];
    rsp_t    rsps[$];

    // Sample just before each rising edge, after the negedge-driven inputs have settled.
    always @(negedge clk) begin
        #4;
        if (write_en || read_en) strobes.push_back('{cyc, write_en, address, data_wr});
        if (write_en && read_en) overlap++;
        if (rsp_valid && rsp_ready) rsps.push_back('{cyc, rsp_rdata});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_logs();
        strobes.delete();
        rsps.delete();
    endtask

    task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d, output int acc);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            if (cmd_ready) begin
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            tests++; fails++;
            $display("FAIL send_timeout: addr %0h never accepted", a);
        end else if (w) begin
            exp_mem[a] = d;
        end
    endtask

    task automatic count_reads(output int n);
        n = 0;
        foreach (strobes[i]) if (!strobes[i].w) n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        tests++;
        if ({write_en, read_en, address, data_wr, rsp_valid, rsp_rdata, busy} !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {write_en, read_en, address, data_wr, rsp_valid, rsp_rdata, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        int acc_w, acc_r;
        rsp_ready = 1'b1;
        clear_logs();
        send(1'b1, 4'h3, 8'hA5, acc_w);
        send(1'b0, 4'h3, 8'h00, acc_r);
        repeat (8) @(negedge clk);
        tests++;
        if (strobes.size() != 2) begin
            fails++; $display("FAIL wr_rd_strobe_count: got %0d want 2", strobes.size());
        end else begin
            tests++;
            if ({strobes[0].w, strobes[0].a, strobes[0].d} !== {1'b1, 4'h3, 8'hA5}) begin
                fails++; $display("FAIL wr_strobe: got %h want 13a5", {strobes[0].w, strobes[0].a, strobes[0].d});
            end
            tests++;
            if (strobes[0].cyc != acc_w + 1) begin
                fails++; $display("FAIL wr_latency: got cycle %0d want %0d", strobes[0].cyc, acc_w + 1);
            end
            tests++;
            if ({strobes[1].w, strobes[1].a} !== {1'b0, 4'h3} || strobes[1].cyc != strobes[0].cyc + 1) begin
                fails++; $display("FAIL rd_strobe: got w=%b a=%h cyc=%0d want w=0 a=3 cyc=%0d",
                                  strobes[1].w, strobes[1].a, strobes[1].cyc, strobes[0].cyc + 1);
            end
            tests++;
            if (rsps.size() != 1) begin
                fails++; $display("FAIL wr_rd_rsp_count: got %0d want 1", rsps.size());
            end else begin
                tests++;
                if (rsps[0].d !== 8'hA5) begin fails++; $display("FAIL wr_rd_data: got %h want a5", rsps[0].d); end
                tests++;
                if (rsps[0].cyc != strobes[1].cyc + 2) begin
                    fails++; $display("FAIL rd_latency: got cycle %0d want %0d", rsps[0].cyc, strobes[1].cyc + 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, nrd;
        rsp_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) send(1'b0, 4'(8 + i), 8'h00, acc);
        repeat (10) @(negedge clk);
        count_reads(nrd);
        tests++;
        if (nrd != 2) begin fails++; $display("FAIL bp_read_pulses: got %0d want 2", nrd); end
        tests++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_cmd_ready: got %b want 0", cmd_ready); end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h48) begin
            fails++; $display("FAIL bp_head: got valid=%b data=%h want 1/48", rsp_valid, rsp_rdata);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (rsp_rdata !== 8'h48 || busy !== 1'b1) begin
            fails++; $display("FAIL bp_stable: got data=%h busy=%b want 48/1", rsp_rdata, busy);
        end
        rsp_ready = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (rsps.size() != 6) begin
            fails++; $display("FAIL bp_drain_count: got %0d want 6", rsps.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (rsps[i].d !== 8'(8'h48 + i)) begin
                    fails++; $display("FAIL bp_drain_data[%0d]: got %h want %h", i, rsps[i].d, 8'(8'h48 + i));
                end
            end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [3:0] kinds;
        rsp_ready = 1'b1;
        clear_logs();
        send(1'b1, 4'h0, 8'h11, acc);
        send(1'b0, 4'h0, 8'h00, acc);
        send(1'b1, 4'h0, 8'h22, acc);
        send(1'b0, 4'h0, 8'h00, acc);
        repeat (10) @(negedge clk);
        tests++;
        if (strobes.size() != 4) begin
            fails++; $display("FAIL b2b_strobe_count: got %0d want 4", strobes.size());
        end else begin
            kinds = {strobes[0].w, strobes[1].w, strobes[2].w, strobes[3].w};
            tests++;
            if (kinds !== 4'b1010) begin fails++; $display("FAIL b2b_order: got %b want 1010", kinds); end
            tests++;
            if (strobes[3].cyc != strobes[0].cyc + 3) begin
                fails++; $display("FAIL b2b_consecutive: got span %0d want 3", strobes[3].cyc - strobes[0].cyc);
            end
        end
        tests++;
        if (rsps.size() != 2) begin
            fails++; $display("FAIL b2b_rsp_count: got %0d want 2", rsps.size());
        end else begin
            tests++;
            if ({rsps[0].d, rsps[1].d} !== 16'h1122) begin
                fails++; $display("FAIL b2b_rsp_data: got %h want 1122", {rsps[0].d, rsps[1].d});
            end
        end
    endtask

    task automatic test_wrap();
        int acc;
        rsp_ready = 1'b1;
        clear_logs();
        send(1'b1, 4'hF, 8'hFF, acc);
        send(1'b0, 4'hF, 8'h00, acc);
        repeat (8) @(negedge clk);
        tests++;
        if (strobes.size() != 2) begin
            fails++; $display("FAIL wrap_strobe_count: got %0d want 2", strobes.size());
        end else begin
            tests++;
            if ({strobes[0].a, strobes[1].a} !== 8'hFF) begin
                fails++; $display("FAIL wrap_addr: got %h want ff", {strobes[0].a, strobes[1].a});
            end
        end
        tests++;
        if (rsps.size() != 1 || rsps[0].d !== 8'hFF) begin
            fails++; $display("FAIL wrap_rsp: got count=%0d want 1 with data ff", rsps.size());
        end
    endtask

    task automatic test_reset_midflight();
        int acc;
        bit seen;
        rsp_ready = 1'b1;
        clear_logs();
        send(1'b0, 4'h5, 8'h00, acc);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (read_en) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL midflight_read_en: got none want 1 pulse"); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({cmd_ready, write_en, read_en, address, data_wr, rsp_valid, rsp_rdata, busy} !== 25'h0) begin
            fails++; $display("FAIL midflight_reset_outputs: got %h want 0",
                              {cmd_ready, write_en, read_en, address, data_wr, rsp_valid, rsp_rdata, busy});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (rsps.size() != 0) begin fails++; $display("FAIL midflight_discard: got %0d responses want 0", rsps.size()); end
        clear_logs();
        send(1'b0, 4'h3, 8'h00, acc);
        repeat (6) @(negedge clk);
        tests++;
        if (rsps.size() != 1 || rsps[0].d !== 8'hA5) begin
            fails++; $display("FAIL midflight_recover: got count=%0d want 1 with data a5", rsps.size());
        end
    endtask

    task automatic test_random_toggle();
        logic [7:0] expq[$];
        logic [3:0] a;
        int acc, nrd;
        bit done;
        rsp_ready = 1'b0;
        overlap = 0;
        clear_logs();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    a = 4'($urandom_range(0, 15));
                    expq.push_back(exp_mem[a]);
                    send(1'b0, a, 8'h00, acc);
                end
                for (int n = 0; n < 400; n++) begin
                    if (rsps.size() >= 20) break;
                    @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!done) rsp_ready = !rsp_ready;
                end
            end
        join
        repeat (4) @(negedge clk);
        count_reads(nrd);
        tests++;
        if (nrd != 20) begin fails++; $display("FAIL rand_read_pulses: got %0d want 20", nrd); end
        tests++;
        if (rsps.size() != 20) begin
            fails++; $display("FAIL rand_rsp_count: got %0d want 20", rsps.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                tests++;
                if (rsps[i].d !== expq[i]) begin
                    fails++; $display("FAIL rand_rsp[%0d]: got %h want %h", i, rsps[i].d, expq[i]);
                end
            end
        end
        tests++;
        if (overlap != 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'(8'h40 + i);
            exp_mem[i] = 8'(8'h40 + i);
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_midflight();
        test_random_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
